// File: rtl/r32i_lsu_pkg.sv
// Shared types and Funct3 encodings for the RV32I load/store unit.
package r32i_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    LOAD_DONE   = 2'd1,
    STORE_WRITE = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align_r32i.sv
// Combinational lane logic: load byte/half extract with extension, and
// sub-word store merge into a previously read word (little-endian lanes).
module lsu_align_r32i
  import r32i_lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  b_lane;
  logic [15:0] h_lane;

  always_comb begin
    case (byte_off)
      2'd0:    b_lane = word[7:0];
      2'd1:    b_lane = word[15:8];
      2'd2:    b_lane = word[23:16];
      default: b_lane = word[31:24];
    endcase
    h_lane = byte_off[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_B:    load_data = {{24{b_lane[7]}}, b_lane};
      F3_BU:   load_data = {24'd0, b_lane};
      F3_H:    load_data = {{16{h_lane[15]}}, h_lane};
      F3_HU:   load_data = {16'd0, h_lane};
      F3_W:    load_data = word;
      default: load_data = '0;
    endcase

    store_word = word;
    if (funct3 == F3_H) begin
      if (byte_off[1]) store_word[31:16] = store_data[15:0];
      else             store_word[15:0]  = store_data[15:0];
    end else begin
      case (byte_off)
        2'd0:    store_word[7:0]   = store_data[7:0];
        2'd1:    store_word[15:8]  = store_data[7:0];
        2'd2:    store_word[23:16] = store_data[7:0];
        default: store_word[31:24] = store_data[7:0];
      endcase
    end
  end

endmodule

// File: rtl/lsu_r32i.sv
// RV32I load/store unit: word stores in one cycle, loads in two, sub-word
// stores as a two-cycle read-modify-write; yields the RAM port to the I-cache.
module lsu_r32i
  import r32i_lsu_pkg::*;
#(
  parameter int dataW       = 32,
  parameter int RAMAddrSize = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   LoadReq,
  input  logic                   StoreReq,
  input  logic [2:0]             Funct3,
  input  logic [dataW-1:0]       Addr,
  input  logic [dataW-1:0]       StoreData,
  input  logic                   InsCacheStall,
  input  logic [dataW-1:0]       RAMOut,
  output logic [RAMAddrSize-1:0] RAMAddr,
  output logic [dataW-1:0]       RAMDataIn,
  output logic                   RAMWriteControl,
  output logic [dataW-1:0]       LoadData,
  output logic                   LSUStall,
  output logic                   LSUFault
);

  lsu_state_t       state_q, state_d;
  logic [dataW-1:0] word_q, word_d;
  logic [dataW-1:0] load_ext, merged;
  logic             ld_fault, st_fault;
  logic             addr_hi_unused;

  // Upper address bits are dropped so accesses wrap modulo the RAM size.
  assign addr_hi_unused = ^Addr[dataW-1:RAMAddrSize+2];

  lsu_align_r32i u_align (
    .word       (word_q),
    .byte_off   (Addr[1:0]),
    .funct3     (Funct3),
    .store_data (StoreData),
    .load_data  (load_ext),
    .store_word (merged)
  );

  always_comb begin
    ld_fault = (Funct3 == 3'b011) || (Funct3 == 3'b110) || (Funct3 == 3'b111) ||
               ((Funct3 == F3_W) && (Addr[1:0] != 2'b00)) ||
               (((Funct3 == F3_H) || (Funct3 == F3_HU)) && Addr[0]);
    st_fault = !((Funct3 == F3_B) || (Funct3 == F3_H) || (Funct3 == F3_W)) ||
               ((Funct3 == F3_W) && (Addr[1:0] != 2'b00)) ||
               ((Funct3 == F3_H) && Addr[0]);
  end

  always_comb begin
    state_d         = state_q;
    word_d          = word_q;
    RAMAddr         = Addr[RAMAddrSize+1:2];
    RAMDataIn       = StoreData;
    RAMWriteControl = 1'b0;
    LoadData        = '0;
    LSUStall        = 1'b0;
    LSUFault        = 1'b0;

    case (state_q)
      IDLE: begin
        if (InsCacheStall) begin
          LSUStall = LoadReq || StoreReq;
        end else if (LoadReq) begin
          if (ld_fault) begin
            LSUFault = 1'b1;
          end else begin
            LSUStall = 1'b1;
            word_d   = RAMOut;
            state_d  = LOAD_DONE;
          end
        end else if (StoreReq) begin
          if (st_fault) begin
            LSUFault = 1'b1;
          end else if (Funct3 == F3_W) begin
            RAMWriteControl = 1'b1;
          end else begin
            LSUStall = 1'b1;
            word_d   = RAMOut;
            state_d  = STORE_WRITE;
          end
        end
      end
      LOAD_DONE: begin
        LoadData = load_ext;
        if (InsCacheStall) LSUStall = 1'b1;
        else               state_d  = IDLE;
      end
      STORE_WRITE: begin
        RAMDataIn = merged;
        if (InsCacheStall) begin
          LSUStall = 1'b1;
        end else begin
          RAMWriteControl = 1'b1;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded combinationally, so reset must mask them directly.
    if (reset) begin
      RAMAddr         = '0;
      RAMDataIn       = '0;
      RAMWriteControl = 1'b0;
      LoadData        = '0;
      LSUStall        = 1'b0;
      LSUFault        = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
    end
  end

endmodule
